// File: rtl/preio_lane_pkg.sv
// Shared types and constants for the PREIO lane arbiter: FSM states, line levels, default widths.
// PREIO_LANE_ARB_PARITY_EN adds the PAR state used for the even-parity frame bit.
package preio_lane_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LINE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ID    = 3'd2,
    S_DATA  = 3'd3,
`ifdef PREIO_LANE_ARB_PARITY_EN
    S_PAR   = 3'd4,
`endif
    S_STOP  = 3'd5
  } lane_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/preio_rr_arb.sv
// Round-robin picker: first active request at or above ptr, wrapping modulo N_REQ.
module preio_rr_arb
  import preio_lane_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win,
  output logic [ID_W-1:0]  win_idx
);

  always_comb begin
    int   k;
    logic found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        win[k]  = 1'b1;
        win_idx = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/preio_lane_arb.sv
// Arbitrates N_REQ requesters onto one serial lane: start, ID, DATA, optional parity, stop.
// Define PREIO_LANE_ARB_PARITY_EN to insert an even-parity bit over ID and DATA.
module preio_lane_arb
  import preio_lane_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                      FPGA_CLK,
  input  logic                      FPGA_RST,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*DATA_W-1:0]   DATA,
  output logic [N_REQ-1:0]          GNT,
  output logic                      DONE,
  output logic                      BUSY,
  output logic                      FPGA_OUT,
  output logic [2:0]                STATE
);

  localparam int CNT_W = max_int($clog2(max_int(ID_W, DATA_W)), 1);

  lane_state_e       state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_idx;
  logic [N_REQ-1:0]  win;
  logic [ID_W-1:0]   id_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] sel_data;
  logic [CNT_W-1:0]  cnt;
  logic              last_id;
  logic              last_data;
`ifdef PREIO_LANE_ARB_PARITY_EN
  logic              par_bit;
`endif

  preio_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req     (REQ),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  assign sel_data  = DATA[int'(win_idx)*DATA_W +: DATA_W];
  assign last_id   = (cnt == CNT_W'(ID_W - 1));
  assign last_data = (cnt == CNT_W'(DATA_W - 1));
  assign STATE     = state;

  // The state names the bit driven on the next edge, so the line trails the state by one cycle.
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state    <= S_IDLE;
      FPGA_OUT <= IDLE_LINE;
      GNT      <= '0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
      ptr      <= '0;
      id_sr    <= '0;
      data_sr  <= '0;
      cnt      <= '0;
`ifdef PREIO_LANE_ARB_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      GNT  <= '0;
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          FPGA_OUT <= IDLE_LINE;
          BUSY     <= 1'b0;
          if (|REQ) begin
            GNT     <= win;
            BUSY    <= 1'b1;
            id_sr   <= win_idx;
            data_sr <= sel_data;
            ptr     <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            cnt     <= '0;
`ifdef PREIO_LANE_ARB_PARITY_EN
            par_bit <= ^{win_idx, sel_data};
`endif
            state   <= S_START;
          end
        end
        S_START: begin
          FPGA_OUT <= START_BIT;
          cnt      <= '0;
          state    <= S_ID;
        end
        S_ID: begin
          FPGA_OUT <= id_sr[0];
          id_sr    <= id_sr >> 1;
          if (last_id) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          FPGA_OUT <= data_sr[0];
          data_sr  <= data_sr >> 1;
          if (last_data) begin
            cnt   <= '0;
`ifdef PREIO_LANE_ARB_PARITY_EN
            state <= S_PAR;
`else
            state <= S_STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PREIO_LANE_ARB_PARITY_EN
        S_PAR: begin
          FPGA_OUT <= par_bit;
          state    <= S_STOP;
        end
`endif
        S_STOP: begin
          FPGA_OUT <= STOP_BIT;
          DONE     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_preio_lane_arb.sv
// Directed bench for preio_lane_arb: grants and frames are predicted into queues and popped as the DUT produces them.
module tb_preio_lane_arb;
  import preio_lane_pkg::*;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;
`ifdef PREIO_LANE_ARB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_LEN = 2 + ID_W + DATA_W + PAR_W;

  logic                    fpga_clk = 1'b0;
  logic                    fpga_rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_bus;
  logic [N_REQ-1:0]        gnt;
  logic                    done;
  logic                    busy;
  logic                    fpga_out;
  logic [2:0]              state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [FRAME_LEN-1:0] exp_q[$];
  logic [N_REQ-1:0]     exp_gnt_q[$];

  preio_lane_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .FPGA_CLK (fpga_clk),
    .FPGA_RST (fpga_rst),
    .REQ      (req),
    .DATA     (data_bus),
    .GNT      (gnt),
    .DONE     (done),
    .BUSY     (busy),
    .FPGA_OUT (fpga_out),
    .STATE    (state)
  );

  // clock / reset
  always #5 fpga_clk = ~fpga_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge fpga_clk);
  endtask

  // frame model: bit 0 goes on the line first
  function automatic logic [FRAME_LEN-1:0] build_frame(input int idx, input logic [DATA_W-1:0] d);
    logic [FRAME_LEN-1:0] f;
    logic [ID_W-1:0]      id;
    id = ID_W'(idx);
    f  = '0;
    f[0] = 1'b1;
    f[1 +: ID_W] = id;
    f[1 + ID_W +: DATA_W] = d;
`ifdef PREIO_LANE_ARB_PARITY_EN
    f[FRAME_LEN-2] = ^{id, d};
`endif
    f[FRAME_LEN-1] = 1'b0;
    return f;
  endfunction

  task automatic do_reset();
    fpga_rst = 1'b1;
    req      = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out", 32'(fpga_out), 32'h0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    fpga_rst = 1'b0;
  endtask

  task automatic expect_grant(input int idx);
    exp_gnt_q.push_back(N_REQ'(1) << idx);
    exp_q.push_back(build_frame(idx, data_bus[idx*DATA_W +: DATA_W]));
  endtask

  task automatic wait_grant(output int n, output logic [FRAME_LEN-1:0] f, output bit ok);
    logic [N_REQ-1:0] eg;
    n  = 0;
    ok = 1'b0;
    eg = exp_gnt_q.pop_front();
    f  = exp_q.pop_front();
    while (n < 40) begin
      tick();
      n++;
      if (gnt != '0) break;
    end
    chk("grant_onehot", 32'(gnt), 32'(eg));
    if (gnt == '0) return;
    chk("grant_line_idle", 32'(fpga_out), 32'h0);
    chk("grant_busy", 32'(busy), 32'h1);
    chk("grant_done", 32'(done), 32'h0);
    ok = 1'b1;
  endtask

  task automatic check_frame(input logic [N_REQ-1:0] clr_mask, input logic [N_REQ-1:0] late_mask,
                             input int late_at, input bit scramble, input int exp_gap);
    int                   n;
    int                   idx;
    bit                   ok;
    logic [FRAME_LEN-1:0] f;
    wait_grant(n, f, ok);
    if (!ok) return;
    if (exp_gap >= 0) chk("frame_gap", 32'(n), 32'(exp_gap));
    idx = 0;
    for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
    req = req & ~clr_mask;
    if (scramble) data_bus[idx*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    for (int b = 0; b < FRAME_LEN; b++) begin
      if (b == late_at) req = req | late_mask;
      tick();
      chk($sformatf("frame_bit%0d", b), 32'(fpga_out), 32'(f[b]));
      chk($sformatf("frame_done%0d", b), 32'(done), 32'(b == FRAME_LEN - 1));
      chk("frame_busy", 32'(busy), 32'h1);
      chk("frame_no_gnt", 32'(gnt), 32'h0);
    end
  endtask

  initial begin
    int                   n;
    bit                   ok;
    logic [FRAME_LEN-1:0] f;

    fpga_rst = 1'b1;
    req      = '0;
    data_bus = {8'hC3, 8'h5A, 8'hA5, 8'h3C};
    do_reset();

    // line stays idle with no request
    repeat (3) tick();
    chk("idle_out", 32'(fpga_out), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_gnt", 32'(gnt), 32'h0);

    // single request from requester 1, payload A5; data changed after grant must not matter
    req = 4'b0010;
    expect_grant(1);
    check_frame(4'b0010, 4'b0000, -1, 1'b1, 1);
    tick();
    chk("post_frame_busy", 32'(busy), 32'h0);
    chk("post_frame_out", 32'(fpga_out), 32'h0);
    chk("post_frame_done", 32'(done), 32'h0);

    // payload 07 from requester 1 (parity bit 0 when enabled)
    data_bus[15:8] = 8'h07;
    req = 4'b0010;
    expect_grant(1);
    check_frame(4'b0010, 4'b0000, -1, 1'b0, -1);

    // all requesters held: 0,1,2,3,0 with one idle cycle between frames
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) expect_grant(k % 4);
    for (int k = 0; k < 5; k++) check_frame((k == 4) ? 4'b1111 : 4'b0000, 4'b0000, -1, 1'b0, 1);

    // fairness after skip: last grant 2, then 0101 -> 0 before 2
    req = 4'b0100;
    expect_grant(2);
    check_frame(4'b0100, 4'b0000, -1, 1'b0, 1);
    req = 4'b0101;
    expect_grant(0);
    expect_grant(2);
    check_frame(4'b0001, 4'b0000, -1, 1'b0, 1);
    check_frame(4'b0100, 4'b0000, -1, 1'b0, 1);

    // late request from requester 3 arriving mid-frame
    req = 4'b0001;
    expect_grant(0);
    expect_grant(3);
    check_frame(4'b0001, 4'b1000, 4, 1'b0, 1);
    check_frame(4'b1000, 4'b0000, -1, 1'b0, 1);

    // reset in the middle of the DATA field
    req = 4'b1111;
    expect_grant(0);
    wait_grant(n, f, ok);
    for (int b = 0; b < 5; b++) begin
      tick();
      chk($sformatf("abort_bit%0d", b), 32'(fpga_out), 32'(f[b]));
    end
    chk("abort_in_data", 32'(state), 32'(S_DATA));
    #2 fpga_rst = 1'b1;
    #1;
    chk("abort_out", 32'(fpga_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_gnt", 32'(gnt), 32'h0);
    tick();
    tick();
    chk("abort_no_done", 32'(done), 32'h0);
    fpga_rst = 1'b0;
    expect_grant(0);
    check_frame(4'b1111, 4'b0000, -1, 1'b0, 1);

    repeat (4) tick();
    chk("end_idle_out", 32'(fpga_out), 32'h0);
    chk("end_idle_busy", 32'(busy), 32'h0);
    chk("end_idle_gnt", 32'(gnt), 32'h0);
    chk("sb_empty", 32'(exp_q.size() + exp_gnt_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/preio_lane_arb.md
PREIO_LANE_ARB -- requirements
Module: preio_lane_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the lane (2..16).
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per frame.
REQ-003 SHALL have parameter ID_W, default $clog2(N_REQ), requester-ID field width.
REQ-004 SHALL have port FPGA_CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port FPGA_RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port REQ  input  N_REQ  per-requester send request, level, held until granted.
REQ-007 SHALL have port DATA  input  N_REQ*DATA_W  payload, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port GNT  output  N_REQ  one-hot, one-cycle pulse; payload captured that cycle.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse in the final frame-bit cycle.
REQ-010 SHALL have port BUSY  output  1  high from the grant cycle through the final frame bit.
REQ-011 SHALL have port FPGA_OUT  output  1  registered serial line toward the PREIO buffer cell.

Function
REQ-012 SHALL implement states IDLE, START, ID, DATA, (PAR), STOP.
REQ-013 IDLE: when REQ != 0, SHALL pulse GNT for the round-robin winner, capture its DATA and ID, go to START.
REQ-014 Round-robin SHALL search from (last_granted+1) mod N_REQ upward; pointer is index 0 after reset.
REQ-015 Frame on FPGA_OUT, one bit per cycle from the cycle after the grant: start bit 1; ID, ID_W bits LSB first; DATA, DATA_W bits LSB first; optional parity; stop bit 0.
REQ-016 Idle line level SHALL be 0.
REQ-017 Frame length: 2+ID_W+DATA_W cycles (12 at defaults), +1 with parity.
REQ-018 DONE SHALL pulse while the stop bit is driven; the FSM then returns to IDLE.
REQ-019 Arbitration SHALL occur only in IDLE, giving a minimum gap of one idle cycle (line 0) between frames.
REQ-020 REQ changes during a frame SHALL have no effect on that frame; a REQ dropped before grant is not served.
REQ-021 Bit counter SHALL be sized for max(ID_W, DATA_W) and SHALL clear on every field transition.

Reset
REQ-022 On FPGA_RST, asynchronously: state IDLE, FPGA_OUT=0, GNT=0, DONE=0, BUSY=0, RR pointer=0, shift registers=0.
REQ-023 Reset mid-frame SHALL abort the frame with no DONE; after release, arbitration restarts from index 0.

Configuration
REQ-024 With PREIO_LANE_ARB_PARITY_EN defined, an even-parity bit over ID and DATA SHALL be inserted before the stop bit (PAR state).
REQ-025 Without PREIO_LANE_ARB_PARITY_EN, the PAR state and parity logic SHALL be absent.

Structure
REQ-026 A shared package preio_lane_pkg SHALL hold the state enum, the start/stop/idle line constants and the default widths.
REQ-027 Round-robin selection SHALL be a sub-module preio_rr_arb (inputs: REQ, pointer; output: one-hot winner plus index).

Verification
REQ-028 Single request: REQ=4'b0010, DATA[15:8]=8'hA5 -> GNT=0010 one cycle; FPGA_OUT = 1,1,0,1,0,1,0,0,1,0,1,0; DONE on cycle 12.
REQ-029 All requests: REQ=4'b1111 held, re-asserted after each grant -> grant order 0,1,2,3,0; one idle cycle between frames.
REQ-030 Fairness after skip: last grant 2, REQ=4'b0101 -> next grant 0 (search starts at index 3).
REQ-031 Reset mid-frame: assert FPGA_RST during the DATA state -> FPGA_OUT=0 and BUSY=0 immediately, no DONE; after release, REQ=1111 -> grant 0.
REQ-032 Parity build: DATA=8'h07 from requester 1 -> parity bit 0 (ID ones 1, data ones 3); frame is 13 cycles.
REQ-033 Late request: REQ[3] asserted while a frame is in flight -> no GNT until IDLE; granted on the first IDLE cycle.
